// File: rtl/set_bit_iterator.sv
// ============================================================================
//  Module   : set_bit_iterator
//  Purpose  : Accepts an N-bit flag word and emits one beat per set bit,
//             lowest index first; an all-zero word yields one empty beat.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module set_bit_iterator #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_last,
    output logic             out_empty
);

    localparam logic [0:0]   c_st_idle = 1'b0;
    localparam logic [0:0]   c_st_busy = 1'b1;
    localparam logic [N-1:0] c_one     = {{(N-1){1'b0}}, 1'b1};

    // Mask of every bit position whose index has bit b set; OR-ing the
    // one-hot vector through these masks encodes its position.
    function automatic logic [N-1:0] index_mask(input int b);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = ((i >> b) & 1) == 1;
        end
        return m;
    endfunction

    logic [0:0]       r_state;
    logic [N-1:0]     r_pend;

    logic             w_busy;
    logic [N-1:0]     w_lowest;
    logic [N-1:0]     w_rest;
    logic [IDX_W-1:0] w_idx;
    logic             w_accept;
    logic             w_fire;

    assign w_busy   = (r_state == c_st_busy);
    assign w_lowest = r_pend & (~r_pend + c_one);
    assign w_rest   = r_pend & ~w_lowest;

    for (genvar b = 0; b < IDX_W; b++) begin : g_idx
        localparam logic [N-1:0] c_mask = index_mask(b);
        assign w_idx[b] = |(w_lowest & c_mask);
    end

    assign w_accept = in_valid & ~w_busy;
    assign w_fire   = w_busy & out_ready;

    // Outputs depend only on registered state, never on the input side.
    assign in_ready   = ~w_busy;
    assign out_valid  = w_busy;
    assign out_onehot = w_busy ? w_lowest : '0;
    assign out_idx    = w_busy ? w_idx : '0;
    assign out_empty  = w_busy & (r_pend == '0);
    assign out_last   = w_busy & (w_rest == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_pend  <= '0;
        end else begin
            if (w_accept) begin
                r_pend  <= in_data;
                r_state <= c_st_busy;
            end else if (w_fire) begin
                r_pend <= w_rest;
                if (w_rest == '0) begin
                    r_state <= c_st_idle;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_set_bit_iterator.sv
// ============================================================================
//  Module   : tb_set_bit_iterator
//  Purpose  : Directed and randomized self-checking bench for set_bit_iterator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_set_bit_iterator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic [31:0] out_onehot;
    logic        out_last;
    logic        out_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    set_bit_iterator #(.N(32), .IDX_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_last   (out_last),
        .out_empty  (out_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idx"},       32'(out_idx),   32'd0);
        check({tag, "_onehot"},    out_onehot,     32'd0);
        check({tag, "_last"},      32'(out_last),  32'd0);
        check({tag, "_empty"},     32'(out_empty), 32'd0);
    endtask

    // Reference beat: e < 0 denotes the empty beat of an all-zero word.
    task automatic check_beat(input string tag, input int e, input bit last);
        logic [31:0] one;
        one = 32'd1;
        check({tag, "_valid"},    32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready),  32'd0);
        check({tag, "_idx"},      32'(out_idx),   (e < 0) ? 32'd0 : 32'(e));
        check({tag, "_onehot"},   out_onehot,     (e < 0) ? 32'd0 : (one << e));
        check({tag, "_last"},     32'(out_last),  32'(last));
        check({tag, "_empty"},    32'(out_empty), 32'(e < 0));
    endtask

    // mode 0: out_ready always high; 1: random backpressure and noisy in_valid;
    // 2: out_ready low for the first three beat cycles, then high.
    task automatic run_word(input string tag, input logic [31:0] w, input int mode);
        int q[$];
        int stall;
        int guard;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) q.push_back(i);
        end
        if (q.size() == 0) q.push_back(-1);
        check_idle({tag, "_pre"});
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        stall    = (mode == 2) ? 3 : 0;
        guard    = 0;
        while (q.size() > 0 && guard < 400) begin
            check_beat(tag, q[0], q.size() == 1);
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    in_valid  = $urandom_range(0, 1) == 1;
                    in_data   = $urandom;
                end
                default: begin
                    out_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
            endcase
            @(negedge clk);
            if (out_ready) void'(q.pop_front());
            guard++;
        end
        if (q.size() != 0) check({tag, "_timeout"}, 32'(q.size()), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_idle({tag, "_post"});
    endtask

    initial begin
        logic [31:0] w;

        // Reset state while rst is held low
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        run_word("two_ends", 32'h8000_0001, 0);
        run_word("zero",     32'h0000_0000, 0);
        run_word("all_ones", 32'hFFFF_FFFF, 0);
        run_word("stall",    32'h0000_0014, 2);

        // Reset asserted mid-word after beats idx 4 and 5 were accepted
        in_valid = 1'b1;
        in_data  = 32'h0000_00F0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_beat("mid_b4", 4, 1'b0);
        @(negedge clk);
        check_beat("mid_b5", 5, 1'b0);
        @(negedge clk);
        check_beat("mid_b6", 6, 1'b0);
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_release");
        run_word("post_rst", 32'h0000_0002, 0);

        // Word B held on in_valid while word A is still being expanded
        in_valid = 1'b1;
        in_data  = 32'h0000_0003;
        @(negedge clk);
        in_data   = 32'h0000_0008;
        out_ready = 1'b1;
        check_beat("hold_a0", 0, 1'b0);
        @(negedge clk);
        check_beat("hold_a1", 1, 1'b1);
        @(negedge clk);
        check_idle("hold_gap");
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("hold_b3", 3, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        check_idle("hold_done");

        // Randomized words with a mix of densities
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: w = $urandom;
                1: w = $urandom & $urandom & $urandom;
                2: w = 32'd1 << $urandom_range(0, 31);
                3: w = ~(32'd1 << $urandom_range(0, 31));
                default: w = '0;
            endcase
            run_word("rand", w, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
